// File: rtl/bin_to_bcd_encoder.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_encoder
//
// Purpose:
//   Converts a 16-bit binary operand into 4-digit packed BCD. The conversion
//   is sequential (double dabble, one step per clock) and takes 16 CONV
//   cycles. Magnitudes above 9999 report an error pattern of 16'hCCCC.
//
// Ports:
//   clk        in   1   rising-edge clock for all state
//   rst        in   1   asynchronous, active-high reset
//   in_valid   in   1   in_bin is valid this cycle
//   in_ready   out  1   block accepts an operand this cycle (IDLE only)
//   in_bin     in  16   binary operand
//   out_valid  out  1   result outputs valid (DONE only)
//   out_ready  in   1   consumer accepts the result
//   out_bcd    out 16   packed BCD result, digit 3 in [15:12]
//   out_err    out  1   magnitude exceeded 9999 (out_bcd = 16'hCCCC)
//   out_neg    out  1   operand was negative (signed build only)
//
// Configuration:
//   SIGNED_IN_EN  when defined, in_bin is two's complement and the magnitude
//                 is converted with the sign reported on out_neg. When not
//                 defined, in_bin is unsigned and out_neg is always 0.
// ---------------------------------------------------------------------------
module bin_to_bcd_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_bin,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_bcd,
    output logic        out_err,
    output logic        out_neg
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [4:0]  LAST_STEP   = 5'd15;
    localparam logic [15:0] ERR_PATTERN = 16'hCCCC;

    // Double-dabble correction for one BCD digit: digits >= 5 get +3 so that
    // the following left shift carries correctly into the next digit.
    function automatic logic [3:0] add3_digit(input logic [3:0] d);
        logic [3:0] r;
        if (d >= 4'd5) begin
            r = d + 4'd3;
        end else begin
            r = d;
        end
        return r;
    endfunction

    // Apply the +3 correction to all five scratch digits.
    function automatic logic [19:0] dabble_adjust(input logic [19:0] s);
        logic [19:0] r;
        r = 20'd0;
        for (int i = 0; i < 5; i++) begin
            r[i*4 +: 4] = add3_digit(s[i*4 +: 4]);
        end
        return r;
    endfunction

    logic [1:0]  state_q,   state_d;
    logic [4:0]  cnt_q,     cnt_d;
    logic [19:0] scratch_q, scratch_d;
    logic [15:0] mag_q,     mag_d;
    logic        neg_q,     neg_d;
    logic [15:0] bcd_q,     bcd_d;
    logic        err_q,     err_d;
    logic        oneg_q,    oneg_d;

    logic [15:0] mag_in_s;
    logic        neg_in_s;
    logic [19:0] adj_s;
    logic [35:0] shifted_s;
    logic        step_err_s;

    // Operand magnitude and sign as seen at the accept edge.
    always_comb begin
`ifdef SIGNED_IN_EN
        neg_in_s = in_bin[15];
        if (in_bin[15]) begin
            mag_in_s = 16'd0 - in_bin;
        end else begin
            mag_in_s = in_bin;
        end
`else
        neg_in_s = 1'b0;
        mag_in_s = in_bin;
`endif
    end

    // One double-dabble step: correct the digits, then shift {scratch, mag}
    // left by one so the magnitude MSB enters scratch bit 0.
    always_comb begin
        adj_s      = dabble_adjust(scratch_q);
        shifted_s  = {adj_s, mag_q} << 1;
        step_err_s = (shifted_s[35:32] != 4'd0);
    end

    // Next-state logic for the FSM, datapath and output registers.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        scratch_d = scratch_q;
        mag_d     = mag_q;
        neg_d     = neg_q;
        bcd_d     = bcd_q;
        err_d     = err_q;
        oneg_d    = oneg_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    mag_d     = mag_in_s;
                    neg_d     = neg_in_s;
                    scratch_d = 20'd0;
                    cnt_d     = 5'd0;
                    state_d   = ST_CONV;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_CONV: begin
                scratch_d = shifted_s[35:16];
                mag_d     = shifted_s[15:0];
                if (cnt_q == LAST_STEP) begin
                    // Final step: the result is taken from the freshly
                    // shifted scratch, not from scratch_q.
                    state_d = ST_DONE;
                    if (step_err_s) begin
                        bcd_d  = ERR_PATTERN;
                        err_d  = 1'b1;
                        oneg_d = 1'b0;
                    end else begin
                        bcd_d  = shifted_s[31:16];
                        err_d  = 1'b0;
                        oneg_d = neg_q;
                    end
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any conversion in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 5'd0;
            scratch_q <= 20'd0;
            mag_q     <= 16'd0;
            neg_q     <= 1'b0;
            bcd_q     <= 16'h0000;
            err_q     <= 1'b0;
            oneg_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            scratch_q <= scratch_d;
            mag_q     <= mag_d;
            neg_q     <= neg_d;
            bcd_q     <= bcd_d;
            err_q     <= err_d;
            oneg_q    <= oneg_d;
        end
    end

    // Handshake flags decode directly from the state register.
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_bcd   = bcd_q;
    assign out_err   = err_q;
    assign out_neg   = oneg_q;

endmodule

// File: tb/tb_bin_to_bcd_encoder.sv
module tb_bin_to_bcd_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_bcd;
    logic        out_err;
    logic        out_neg;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] bin;
        logic [15:0] bcd;
        logic        err;
        logic        neg;
    } vec_t;

    vec_t vecs[12];
    logic [17:0] sb_q[$];

    bin_to_bcd_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bin    (in_bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
        .out_err   (out_err),
        .out_neg   (out_neg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int w = 0;
        while (!in_ready && w < 40) begin
            @(posedge clk); #1;
            w++;
        end
        chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    endtask

    // Accept one operand, push expectation, wait for result and compare.
    task automatic convert(input string name, input logic [15:0] bin,
                           input logic [15:0] bcd, input logic err, input logic neg);
        int cyc;
        logic [17:0] exp;
        wait_ready();
        in_bin   = bin;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_bin   = 16'hA5A5;
        sb_q.push_back({bcd, err, neg});
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({name, "_latency"}, cyc, 32'd16);
        if (out_valid && sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            chk({name, "_bcd"}, {16'd0, out_bcd}, {16'd0, exp[17:2]});
            chk({name, "_err"}, {31'd0, out_err}, {31'd0, exp[1]});
            chk({name, "_neg"}, {31'd0, out_neg}, {31'd0, exp[0]});
        end else begin
            chk({name, "_timeout"}, 32'd0, 32'd1);
        end
        if (out_ready) begin
            @(posedge clk); #1;
            chk({name, "_ready_after"}, {31'd0, in_ready}, 32'd1);
            chk({name, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
        end
    endtask

    initial begin
        vecs[0]  = '{16'h04D2, 16'h1234, 1'b0, 1'b0};
        vecs[1]  = '{16'h270F, 16'h9999, 1'b0, 1'b0};
        vecs[2]  = '{16'h2710, 16'hCCCC, 1'b1, 1'b0};
        vecs[3]  = '{16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[4]  = '{16'h0063, 16'h0099, 1'b0, 1'b0};
        vecs[5]  = '{16'h03E8, 16'h1000, 1'b0, 1'b0};
        vecs[6]  = '{16'h1234, 16'h4660, 1'b0, 1'b0};
        vecs[7]  = '{16'h0005, 16'h0005, 1'b0, 1'b0};
        vecs[8]  = '{16'h8000, 16'hCCCC, 1'b1, 1'b0};
`ifdef SIGNED_IN_EN
        vecs[9]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b1};
        vecs[10] = '{16'hD8F1, 16'h9999, 1'b0, 1'b1};
        vecs[11] = '{16'hFB2E, 16'h1234, 1'b0, 1'b1};
`else
        vecs[9]  = '{16'hFFFF, 16'hCCCC, 1'b1, 1'b0};
        vecs[10] = '{16'hD8F1, 16'hCCCC, 1'b1, 1'b0};
        vecs[11] = '{16'hFB2E, 16'hCCCC, 1'b1, 1'b0};
`endif

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_bin    = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_bcd",   {16'd0, out_bcd},   32'd0);
        chk("rst_out_err",   {31'd0, out_err},   32'd0);
        chk("rst_out_neg",   {31'd0, out_neg},   32'd0);
        rst = 1'b0;

        // Table-driven conversions with out_ready held high.
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            convert($sformatf("vec%0d", i), vecs[i].bin, vecs[i].bcd, vecs[i].err, vecs[i].neg);
        end

        // Result held in DONE while out_ready is low; extra in_valid ignored.
        out_ready = 1'b0;
        convert("hold", 16'h0042, 16'h0066, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_bin   = 16'h1111;
            @(posedge clk); #1;
            chk("hold_valid",    {31'd0, out_valid}, 32'd1);
            chk("hold_bcd",      {16'd0, out_bcd},   32'h0066);
            chk("hold_in_ready", {31'd0, in_ready},  32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("hold_release_ready", {31'd0, in_ready},  32'd1);
        chk("hold_release_valid", {31'd0, out_valid}, 32'd0);
        convert("after_hold", 16'h0007, 16'h0007, 1'b0, 1'b0);

        // Put a nonzero result in the output registers, then reset mid-CONV.
        convert("pre_rst", 16'h0042, 16'h0066, 1'b0, 1'b0);
        wait_ready();
        in_bin   = 16'h1234;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_out_bcd",   {16'd0, out_bcd},   32'd0);
        chk("mid_rst_out_err",   {31'd0, out_err},   32'd0);
        chk("mid_rst_out_neg",   {31'd0, out_neg},   32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        convert("post_rst", 16'h0007, 16'h0007, 1'b0, 1'b0);

        chk("sb_empty", sb_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
